vdp_vram_slot_arbiter: RTL and testbench

Time-slot arbiter sharing the single 128 KiB VRAM port of the IKA9958 VDP between the display fetch engine, the CPU port and the command engine. It divides the 21 MHz enabled clock into fixed 4-tick access slots and grants each slot to one requester by fixed priority plus a command-engine anti-starvation rule. It drives the VRAM address, data and strobe signals for the granted slot and returns read data and a one-cycle acknowledge to the winner. It sits between the VDP core requesters and the VRAM pin interface.

---
 rtl/vdp_vram_slot_arbiter.sv | 158 +++++++++++++++
 tb/tb_vdp_vram_slot_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_vram_slot_arbiter.sv
// VRAM time-slot arbiter: 4-tick slots shared by display, CPU and command engine.
// Optional refresh slots are built in when IKA9958_VRAM_REFRESH_EN is defined.
module vdp_vram_slot_arbiter #(
  parameter int unsigned AW             = 17,
  parameter int unsigned CMD_MAXWAIT    = 8,
  parameter int unsigned REFRESH_PERIOD = 64
) (
  input  logic          i_XTAL1,
  input  logic          i_RST_n,
  input  logic          i_XTAL_NCEN,
  input  logic          i_DISP_REQ,
  input  logic [AW-1:0] i_DISP_ADDR,
  output logic          o_DISP_ACK,
  input  logic          i_CPU_REQ,
  input  logic          i_CPU_WE,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [7:0]    i_CPU_WDATA,
  output logic          o_CPU_ACK,
  input  logic          i_CMD_REQ,
  input  logic          i_CMD_WE,
  input  logic [AW-1:0] i_CMD_ADDR,
  input  logic [7:0]    i_CMD_WDATA,
  output logic          o_CMD_ACK,
  output logic [7:0]    o_RDATA,
  output logic          o_VRAM_CS,
  output logic          o_VRAM_WE,
  output logic [AW-1:0] o_VRAM_ADDR,
  output logic [7:0]    o_VRAM_DOUT,
  input  logic [7:0]    i_VRAM_DIN,
  output logic          o_REFRESH,
  output logic [2:0]    o_SLOT_OWNER
);

  localparam int unsigned SCW = 8;
  localparam logic [2:0] OWN_IDLE = 3'd0;
  localparam logic [2:0] OWN_DISP = 3'd1;
  localparam logic [2:0] OWN_CPU  = 3'd2;
  localparam logic [2:0] OWN_CMD  = 3'd3;
  localparam logic [2:0] OWN_REFR = 3'd4;

  if (REFRESH_PERIOD < 2 || CMD_MAXWAIT < 1 || CMD_MAXWAIT > 255) begin : g_param_check
    $error("vdp_vram_slot_arbiter: parameter out of range");
  end

  logic [1:0]     phase;
  logic [SCW-1:0] starve_cnt;
  logic           refresh_pend;
  logic           tick_ph0_c;
  logic           tick_ph3_c;
  logic           cmd_starved_c;
  logic [2:0]     win_owner_c;
  logic [AW-1:0]  win_addr_c;
  logic           win_we_c;
  logic [7:0]     win_wdata_c;

  assign tick_ph0_c    = i_XTAL_NCEN && (phase == 2'd0);
  assign tick_ph3_c    = i_XTAL_NCEN && (phase == 2'd3);
  assign cmd_starved_c = starve_cnt >= SCW'(CMD_MAXWAIT);

  // Fixed-priority pick for the next slot; display is never delayed.
  always_comb begin
    win_owner_c = OWN_IDLE;
    win_addr_c  = '0;
    win_we_c    = 1'b0;
    win_wdata_c = '0;
    if (i_DISP_REQ) begin
      win_owner_c = OWN_DISP;
      win_addr_c  = i_DISP_ADDR;
    end else if (refresh_pend) begin
      win_owner_c = OWN_REFR;
    end else if (i_CMD_REQ && cmd_starved_c) begin
      win_owner_c = OWN_CMD;
      win_addr_c  = i_CMD_ADDR;
      win_we_c    = i_CMD_WE;
      win_wdata_c = i_CMD_WDATA;
    end else if (i_CPU_REQ) begin
      win_owner_c = OWN_CPU;
      win_addr_c  = i_CPU_ADDR;
      win_we_c    = i_CPU_WE;
      win_wdata_c = i_CPU_WDATA;
    end else if (i_CMD_REQ) begin
      win_owner_c = OWN_CMD;
      win_addr_c  = i_CMD_ADDR;
      win_we_c    = i_CMD_WE;
      win_wdata_c = i_CMD_WDATA;
    end
  end

`ifdef IKA9958_VRAM_REFRESH_EN
  localparam int unsigned RCW = $clog2(REFRESH_PERIOD);
  logic [RCW-1:0] slot_cnt;

  // A new pending request on wrap wins over a same-slot clear; it never stacks.
  always_ff @(posedge i_XTAL1) begin
    if (!i_RST_n) begin
      slot_cnt     <= '0;
      refresh_pend <= 1'b0;
    end else if (tick_ph0_c) begin
      if (slot_cnt == RCW'(REFRESH_PERIOD - 1)) begin
        slot_cnt     <= '0;
        refresh_pend <= 1'b1;
      end else begin
        slot_cnt     <= slot_cnt + RCW'(1);
        refresh_pend <= refresh_pend && (win_owner_c != OWN_REFR);
      end
    end
  end
`else
  assign refresh_pend = 1'b0;
`endif

  always_ff @(posedge i_XTAL1) begin
    if (!i_RST_n) begin
      phase        <= '0;
      starve_cnt   <= '0;
      o_DISP_ACK   <= 1'b0;
      o_CPU_ACK    <= 1'b0;
      o_CMD_ACK    <= 1'b0;
      o_RDATA      <= '0;
      o_VRAM_CS    <= 1'b0;
      o_VRAM_WE    <= 1'b0;
      o_VRAM_ADDR  <= '0;
      o_VRAM_DOUT  <= '0;
      o_REFRESH    <= 1'b0;
      o_SLOT_OWNER <= OWN_IDLE;
    end else begin
      o_DISP_ACK <= 1'b0;
      o_CPU_ACK  <= 1'b0;
      o_CMD_ACK  <= 1'b0;
      if (i_XTAL_NCEN) phase <= phase + 2'd1;

      // Slot start: latch winner and its operands for the whole slot.
      if (tick_ph0_c) begin
        o_SLOT_OWNER <= win_owner_c;
        o_VRAM_CS    <= win_owner_c != OWN_IDLE;
        o_VRAM_WE    <= win_we_c;
        o_VRAM_ADDR  <= win_addr_c;
        o_VRAM_DOUT  <= win_wdata_c;
        o_REFRESH    <= win_owner_c == OWN_REFR;
        if (!i_CMD_REQ || win_owner_c == OWN_CMD) starve_cnt <= '0;
        else if (starve_cnt != '1)               starve_cnt <= starve_cnt + SCW'(1);
      end

      // Slot end: release strobes, return data, acknowledge the owner.
      if (tick_ph3_c) begin
        o_VRAM_CS  <= 1'b0;
        o_VRAM_WE  <= 1'b0;
        o_REFRESH  <= 1'b0;
        o_DISP_ACK <= o_SLOT_OWNER == OWN_DISP;
        o_CPU_ACK  <= o_SLOT_OWNER == OWN_CPU;
        o_CMD_ACK  <= o_SLOT_OWNER == OWN_CMD;
        if (!o_VRAM_WE && (o_SLOT_OWNER inside {OWN_DISP, OWN_CPU, OWN_CMD}))
          o_RDATA <= i_VRAM_DIN;
      end
    end
  end

endmodule

// File: tb/tb_vdp_vram_slot_arbiter.sv
// Scoreboard bench for vdp_vram_slot_arbiter: expected slots are queued as
// requests are issued and matched against each completed VRAM slot.
module tb_vdp_vram_slot_arbiter;

  localparam int unsigned AW         = 17;
  localparam int unsigned CYC_BUDGET = 400;
  localparam logic [2:0] O_DISP = 3'd1;
  localparam logic [2:0] O_CPU  = 3'd2;
  localparam logic [2:0] O_CMD  = 3'd3;
  localparam logic [2:0] O_REFR = 3'd4;

  typedef struct {
    logic [2:0]    owner;
    logic [AW-1:0] addr;
    logic          we;
    logic [7:0]    wdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ncen = 1'b0;
  logic          disp_req = 1'b0, cpu_req = 1'b0, cmd_req = 1'b0;
  logic          cpu_we = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0] disp_addr = '0, cpu_addr = '0, cmd_addr = '0;
  logic [7:0]    cpu_wdata = '0, cmd_wdata = '0;
  logic          disp_ack, cpu_ack, cmd_ack;
  logic [7:0]    rdata;
  logic          vram_cs, vram_we, refresh;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_dout, vram_din;
  logic [2:0]    slot_owner;

  vdp_vram_slot_arbiter #(.AW(AW), .CMD_MAXWAIT(8), .REFRESH_PERIOD(4)) dut (
    .i_XTAL1(clk), .i_RST_n(rst_n), .i_XTAL_NCEN(ncen),
    .i_DISP_REQ(disp_req), .i_DISP_ADDR(disp_addr), .o_DISP_ACK(disp_ack),
    .i_CPU_REQ(cpu_req), .i_CPU_WE(cpu_we), .i_CPU_ADDR(cpu_addr),
    .i_CPU_WDATA(cpu_wdata), .o_CPU_ACK(cpu_ack),
    .i_CMD_REQ(cmd_req), .i_CMD_WE(cmd_we), .i_CMD_ADDR(cmd_addr),
    .i_CMD_WDATA(cmd_wdata), .o_CMD_ACK(cmd_ack),
    .o_RDATA(rdata), .o_VRAM_CS(vram_cs), .o_VRAM_WE(vram_we),
    .o_VRAM_ADDR(vram_addr), .o_VRAM_DOUT(vram_dout), .i_VRAM_DIN(vram_din),
    .o_REFRESH(refresh), .o_SLOT_OWNER(slot_owner)
  );

  function automatic logic [7:0] vram_fn(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  assign vram_din = vram_fn(vram_addr);

  always #5 clk = ~clk;

  // Clock enable: one tick every third clock.
  int unsigned div = 0;
  logic        last_tick = 1'b0;
  always @(negedge clk) begin
    div  = (div == 2) ? 0 : div + 1;
    ncen = (div == 0);
  end
  always @(posedge clk) last_tick <= ncen;

  int   n_err = 0;
  int   n_chk = 0;
  exp_t sb[$];
  logic [7:0] exp_rdata = '0;
  logic mon_en = 1'b0;
  int   refresh_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [2:0] o, input logic [AW-1:0] a,
                               input logic w, input logic [7:0] d);
    exp_t e;
    e.owner = o; e.addr = a; e.we = w; e.wdata = d;
    sb.push_back(e);
  endfunction

  function automatic logic ack_of(input int who);
    case (who)
      1:       return disp_ack;
      2:       return cpu_ack;
      default: return cmd_ack;
    endcase
  endfunction

  // Slot monitor: capture at slot start, compare against the scoreboard at slot end.
  logic          prev_cs = 1'b0;
  logic [2:0]    cap_owner;
  logic [AW-1:0] cap_addr;
  logic          cap_we, cap_refr;
  logic [7:0]    cap_dout;
  int            tick_cnt;
  exp_t          e_mon;
  logic [2:0]    ackv;
  logic          is_end;
  always @(negedge clk) begin
    ackv   = {disp_ack, cpu_ack, cmd_ack};
    is_end = 1'b0;
    if (refresh || slot_owner == O_REFR) refresh_seen++;
    if (!mon_en) prev_cs = 1'b0;
    else begin
      if (vram_cs && !prev_cs) begin
        cap_owner = slot_owner; cap_addr = vram_addr; cap_we = vram_we;
        cap_dout = vram_dout; cap_refr = refresh; tick_cnt = 0;
        check_eq("slot_start_on_tick", 32'(last_tick), 32'd1);
      end else if (vram_cs && last_tick) begin
        tick_cnt++;
      end else if (!vram_cs && prev_cs) begin
        is_end = 1'b1;
        if (sb.size() == 0) check_eq("sb_underflow", 32'(sb.size()), 32'd1);
        else begin
          e_mon = sb.pop_front();
          check_eq("owner", 32'(cap_owner), 32'(e_mon.owner));
          check_eq("owner_held", 32'(slot_owner), 32'(e_mon.owner));
          check_eq("we", 32'(cap_we), 32'(e_mon.we));
          check_eq("refresh_flag", 32'(cap_refr), 32'(e_mon.owner == O_REFR));
          if (e_mon.owner != O_REFR) check_eq("addr", 32'(cap_addr), 32'(e_mon.addr));
          if (e_mon.we) check_eq("wdata", 32'(cap_dout), 32'(e_mon.wdata));
          check_eq("slot_ticks", 32'(tick_cnt), 32'd2);
          check_eq("ack", 32'(ackv), 32'({e_mon.owner == O_DISP, e_mon.owner == O_CPU,
                                           e_mon.owner == O_CMD}));
          if (e_mon.owner != O_REFR && !e_mon.we) exp_rdata = vram_fn(e_mon.addr);
          check_eq("rdata", 32'(rdata), 32'(exp_rdata));
        end
      end
      if (ackv != 3'b000 && !is_end) check_eq("stray_ack", 32'(ackv), 32'd0);
      prev_cs = vram_cs;
    end
  end

  task automatic requester(input int who, input int n, input logic we,
                           input logic [AW-1:0] base, input logic [7:0] dbase);
    for (int k = 0; k < n; k++) begin
      int   cyc;
      logic got;
      case (who)
        1: begin disp_addr = base + AW'(k); disp_req = 1'b1; end
        2: begin cpu_addr = base + AW'(k); cpu_we = we; cpu_wdata = dbase + 8'(k); cpu_req = 1'b1; end
        default: begin cmd_addr = base + AW'(k); cmd_we = we; cmd_wdata = dbase + 8'(k); cmd_req = 1'b1; end
      endcase
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < CYC_BUDGET) begin
        @(negedge clk);
        cyc++;
        got = ack_of(who);
      end
      if (!got) check_eq($sformatf("ack_timeout_%0d", who), 32'(got), 32'd1);
    end
    case (who)
      1:       disp_req = 1'b0;
      2:       cpu_req  = 1'b0;
      default: cmd_req  = 1'b0;
    endcase
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    disp_req = 1'b0; cpu_req = 1'b0; cmd_req = 1'b0;
    repeat (4) @(negedge clk);
    exp_rdata = '0;
  endtask

  task automatic release_reset();
    mon_en = 1'b1;
    rst_n  = 1'b1;
  endtask

  task automatic finish_test(input string tag);
    @(negedge clk);
    mon_en = 1'b0;
    check_eq({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic wait_tick();
    int cyc = 0;
    do begin @(negedge clk); cyc++; end while (!last_tick && cyc < 10);
  endtask

  initial begin
    int cyc;
    // Reset values
    apply_reset();
    check_eq("rst_cs", 32'(vram_cs), 32'd0);
    check_eq("rst_we", 32'(vram_we), 32'd0);
    check_eq("rst_addr", 32'(vram_addr), 32'd0);
    check_eq("rst_dout", 32'(vram_dout), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    check_eq("rst_owner", 32'(slot_owner), 32'd0);
    check_eq("rst_refresh", 32'(refresh), 32'd0);
    check_eq("rst_acks", 32'({disp_ack, cpu_ack, cmd_ack}), 32'd0);

    // Uncontended CPU write
    push(O_CPU, 17'h1ABCD, 1'b1, 8'h5A);
    release_reset();
    requester(2, 1, 1'b1, 17'h1ABCD, 8'h5A);
    @(negedge clk);
    check_eq("cpu_ack_one_cycle", 32'(cpu_ack), 32'd0);
    finish_test("t1");

    // Display and CPU at the same phase 0, then a command read
    apply_reset();
    push(O_DISP, 17'h0003C, 1'b0, 8'h00);
    push(O_CPU, 17'h12345, 1'b0, 8'h00);
    push(O_CMD, 17'h07788, 1'b0, 8'h00);
    release_reset();
    fork
      requester(1, 1, 1'b0, 17'h0003C, 8'h00);
      requester(2, 1, 1'b0, 17'h12345, 8'h00);
    join
    requester(3, 1, 1'b0, 17'h07788, 8'h00);
    finish_test("t2");

`ifndef IKA9958_VRAM_REFRESH_EN
    // Command starvation against a continuous CPU stream
    apply_reset();
    for (int k = 0; k < 8; k++) push(O_CPU, 17'h00100 + AW'(k), 1'b1, 8'h10 + 8'(k));
    push(O_CMD, 17'h1F000, 1'b1, 8'hC3);
    for (int k = 8; k < 11; k++) push(O_CPU, 17'h00100 + AW'(k), 1'b1, 8'h10 + 8'(k));
    release_reset();
    fork
      requester(2, 11, 1'b1, 17'h00100, 8'h10);
      requester(3, 1, 1'b1, 17'h1F000, 8'hC3);
    join
    finish_test("t3");
`endif

    // Reset in the middle of a CPU write slot
    apply_reset();
    rst_n = 1'b1;
    cpu_addr = 17'h0AAAA; cpu_we = 1'b1; cpu_wdata = 8'hA5; cpu_req = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!vram_cs && cyc < 20);
    check_eq("abort_slot_started", 32'(vram_cs), 32'd1);
    wait_tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_cs", 32'(vram_cs), 32'd0);
    check_eq("abort_we", 32'(vram_we), 32'd0);
    check_eq("abort_owner", 32'(slot_owner), 32'd0);
    check_eq("abort_ack", 32'(cpu_ack), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check_eq("abort_no_ack", 32'({disp_ack, cpu_ack, cmd_ack}), 32'd0);
    end
    exp_rdata = '0;
    push(O_CPU, 17'h0AAAA, 1'b1, 8'hA5);
    release_reset();
    wait_tick();
    check_eq("restart_first_tick_cs", 32'(vram_cs), 32'd1);
    requester(2, 1, 1'b1, 17'h0AAAA, 8'hA5);
    finish_test("t4");

`ifdef IKA9958_VRAM_REFRESH_EN
    // Six display slots, then the pending refresh, then the waiting CPU
    apply_reset();
    disp_addr = 17'h00200; disp_req = 1'b1;
    for (int k = 0; k < 6; k++) push(O_DISP, 17'h00200 + AW'(k), 1'b0, 8'h00);
    push(O_REFR, 17'h00000, 1'b0, 8'h00);
    push(O_CPU, 17'h00300, 1'b1, 8'h77);
    release_reset();
    fork
      requester(1, 6, 1'b0, 17'h00200, 8'h00);
      requester(2, 1, 1'b1, 17'h00300, 8'h77);
    join
    finish_test("t5");
`else
    check_eq("refresh_tied_low", 32'(refresh_seen), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
